// File: rtl/utopia_tx_core.sv
// Utopia Level-1 8-bit ATM-layer transmit core: one-cell hold register feeding
// a byte shifter, with optional HEC regeneration and PHY cell-level flow control.
module utopia_tx_core #(
  parameter int IfWidth    = 8,
  parameter int CELL_BYTES = 53,
  parameter int GEN_HEC    = 1
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [CELL_BYTES*8-1:0] cell_in,
  input  logic                    cell_valid,
  output logic                    cell_ready,
  output logic [IfWidth-1:0]      data,
  output logic                    soc,
  output logic                    en,
  input  logic                    clav,
  output logic                    busy,
  output logic [15:0]             cells_sent
);

  localparam int CW = CELL_BYTES * 8;
  localparam logic [5:0] LAST_IDX = 6'(CELL_BYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [CW-1:0]       shift_q, shift_d;
  logic [5:0]          idx_q, idx_d;
  logic [IfWidth-1:0]  data_q, data_d;
  logic                soc_q, soc_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic [15:0]         cells_sent_q, cells_sent_d;
  logic [CW-1:0]       load_cell;
  logic                start;

  // CRC-8 (poly 0x07, init 0) over the four header bytes, MSB first.
  function automatic logic [7:0] crc8(input logic [31:0] hdr);
    logic [7:0] crc;
    logic       fb;
    crc = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      fb  = crc[7] ^ hdr[i];
      crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return crc;
  endfunction

  // Handshake: a cell moves into the hold register on any rising edge where
  // cell_valid && cell_ready; cell_ready is simply "hold register empty".
  assign cell_ready = !hold_full_q;
  assign data       = data_q;
  assign soc        = soc_q;
  assign en         = en_q;
  assign busy       = busy_q;
  assign cells_sent = cells_sent_q;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    data_d       = data_q;
    soc_d        = soc_q;
    en_d         = en_q;
    busy_d       = busy_q;
    cells_sent_d = cells_sent_q;
    start        = 1'b0;

    load_cell = hold_q;
    if (GEN_HEC != 0) begin
      load_cell[CW-33 -: 8] = crc8(hold_q[CW-1 -: 32]) ^ 8'h55;
    end

    // Capture and transfer are mutually exclusive: transfer needs a full hold.
    if (cell_valid && !hold_full_q) begin
      hold_d      = cell_in;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q && clav) begin
          start = 1'b1;
        end else begin
          en_d   = 1'b1;
          soc_d  = 1'b0;
          busy_d = 1'b0;
        end
      end
      SEND: begin
        if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + 6'd1;
          data_d  = shift_q[CW-1 -: IfWidth];
          shift_d = shift_q << IfWidth;
          soc_d   = 1'b0;
          en_d    = 1'b0;
        end else begin
          cells_sent_d = cells_sent_q + 16'd1;
          if (hold_full_q && clav) begin
            start = 1'b1;
          end else begin
            en_d    = 1'b1;
            soc_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Byte 0 goes straight to the bus; the shifter keeps bytes 1..52 at the top.
    if (start) begin
      hold_full_d = 1'b0;
      state_d     = SEND;
      idx_d       = 6'd0;
      data_d      = load_cell[CW-1 -: IfWidth];
      shift_d     = load_cell << IfWidth;
      soc_d       = 1'b1;
      en_d        = 1'b0;
      busy_d      = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      idx_q        <= 6'd0;
      data_q       <= '0;
      soc_q        <= 1'b0;
      en_q         <= 1'b1;
      busy_q       <= 1'b0;
      cells_sent_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      soc_q        <= soc_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      cells_sent_q <= cells_sent_d;
    end
  end

endmodule
